// File: rtl/vga_timing_monitor_if.sv
// Sync stream as driven to the display connector: generator is master, monitor is slave.
interface vga_timing_monitor_if;
    logic hs;
    logic vs;
    logic visible;
    logic p_tick;

    modport master (output hs, output vs, output visible, output p_tick);
    modport slave  (input  hs, input  vs, input  visible, input  p_tick);
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers pixel coordinates from the sync waveform,
// checks line/frame geometry, and reports lock, sticky error flags and a good-frame count.
module vga_timing_monitor #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_TOTAL   = 525,
    parameter bit          SYNC_POL  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    vga_timing_monitor_if.slave vga,
    input  logic                err_clr,
    output logic                locked,
    output logic                pix_valid,
    output logic [9:0]          pix_x,
    output logic [9:0]          pix_y,
    output logic [15:0]         frame_cnt,
    output logic                err_hperiod,
    output logic                err_hactive,
    output logic                err_vtotal,
    output logic                err_vactive
);

    localparam logic [11:0] HTotal = 12'(H_TOTAL);
    localparam logic [10:0] HDisp  = 11'(H_DISPLAY);
    localparam logic [11:0] VTotal = 12'(V_TOTAL);
    localparam logic [11:0] VDisp  = 12'(V_DISPLAY);

    typedef enum logic [1:0] {
        StSeek,
        StMeasure,
        StLocked
    } state_e;

    state_e      state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        vis_prev_q, vis_prev_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [11:0] hper_q, hper_d;
    logic        href_q, href_d;
    logic [10:0] lines_q, lines_d;
    logic [10:0] vlines_q, vlines_d;
    logic        ffail_q, ffail_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_hperiod_q, err_hperiod_d;
    logic        err_hactive_q, err_hactive_d;
    logic        err_vtotal_q, err_vtotal_d;
    logic        err_vactive_q, err_vactive_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        locked_q;

    logic        tick;
    logic        hs_act, vs_act;
    logic        hs_lead, vs_lead, vis_fall;
    logic        active;
    logic [11:0] lines_close, vlines_close;
    logic        hper_bad, hact_bad, vt_bad, va_bad;
    logic        line_fail, frame_fail;
    logic        restart;

    assign tick     = vga.p_tick;
    assign hs_act   = (vga.hs == SYNC_POL);
    assign vs_act   = (vga.vs == SYNC_POL);
    assign hs_lead  = tick & hs_act & ~hs_prev_q;
    assign vs_lead  = tick & vs_act & ~vs_prev_q;
    assign vis_fall = tick & vis_prev_q & ~vga.visible;
    assign active   = (state_q != StSeek);

    // A coincident HS edge / visible fall belongs to the frame that the VS edge closes.
    assign lines_close  = {1'b0, lines_q} + {11'd0, hs_lead};
    assign vlines_close = {1'b0, vlines_q} + {11'd0, vis_fall};

    assign hper_bad   = active & hs_lead & href_q & (hper_q != HTotal);
    assign hact_bad   = active & vis_fall & (({1'b0, x_q} + 11'd1) != HDisp);
    assign vt_bad     = active & vs_lead & (lines_close != VTotal);
    assign va_bad     = active & vs_lead & (vlines_close != VDisp);
    assign line_fail  = hper_bad | hact_bad;
    assign frame_fail = ffail_q | line_fail | vt_bad | va_bad;

    // Coordinate recovery, edge history and period measurement.
    always_comb begin
        hs_prev_d  = hs_prev_q;
        vs_prev_d  = vs_prev_q;
        vis_prev_d = vis_prev_q;
        x_d        = x_q;
        y_d        = y_q;
        hper_d     = hper_q;
        href_d     = href_q;

        if (tick) begin
            hs_prev_d  = hs_act;
            vs_prev_d  = vs_act;
            vis_prev_d = vga.visible;
            if (hs_lead) begin
                hper_d = 12'd1;
            end else if (hper_q != 12'hFFF) begin
                hper_d = hper_q + 12'd1;
            end
        end

        if (tick && vga.visible) begin
            if (!vis_prev_q) begin
                x_d = '0;
            end else if (x_q != 10'h3FF) begin
                x_d = x_q + 10'd1;
            end
        end

        if (vs_lead) begin
            y_d = '0;
        end else if (vis_fall) begin
            y_d = y_q + 10'd1;
        end

        if (!active) begin
            href_d = 1'b0;
        end else if (hs_lead) begin
            href_d = 1'b1;
        end
    end

    // Lock state machine and per-frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        ffail_d     = ffail_q;
        restart     = 1'b0;

        unique case (state_q)
            StSeek: begin
                if (vs_lead) begin
                    state_d = StMeasure;
                    restart = 1'b1;
                end
            end
            StMeasure, StLocked: begin
                if (vs_lead) begin
                    restart = 1'b1;
                    if (frame_fail) begin
                        state_d = StMeasure;
                    end else begin
                        state_d     = StLocked;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else if (line_fail) begin
                    state_d = StMeasure;
                    ffail_d = 1'b1;
                end
            end
            default: begin
                state_d = StSeek;
            end
        endcase

        if (restart) begin
            ffail_d = 1'b0;
        end
    end

    always_comb begin
        lines_d  = lines_q;
        vlines_d = vlines_q;
        if (!active || restart) begin
            lines_d  = '0;
            vlines_d = '0;
        end else begin
            if (hs_lead && (lines_q != 11'h7FF)) begin
                lines_d = lines_q + 11'd1;
            end
            if (vis_fall && (vlines_q != 11'h7FF)) begin
                vlines_d = vlines_q + 11'd1;
            end
        end
    end

    // Sticky flags: a new failure on the clearing clock keeps the flag set.
    always_comb begin
        err_hperiod_d = (err_hperiod_q & ~err_clr) | hper_bad;
        err_hactive_d = (err_hactive_q & ~err_clr) | hact_bad;
        err_vtotal_d  = (err_vtotal_q & ~err_clr) | vt_bad;
        err_vactive_d = (err_vactive_q & ~err_clr) | va_bad;
    end

    always_comb begin
        pix_valid_d = tick & vga.visible & active;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        if (pix_valid_d) begin
            pix_x_d = x_d;
            pix_y_d = y_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StSeek;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            vis_prev_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hper_q        <= '0;
            href_q        <= 1'b0;
            lines_q       <= '0;
            vlines_q      <= '0;
            ffail_q       <= 1'b0;
            frame_cnt_q   <= '0;
            err_hperiod_q <= 1'b0;
            err_hactive_q <= 1'b0;
            err_vtotal_q  <= 1'b0;
            err_vactive_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            vis_prev_q    <= vis_prev_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hper_q        <= hper_d;
            href_q        <= href_d;
            lines_q       <= lines_d;
            vlines_q      <= vlines_d;
            ffail_q       <= ffail_d;
            frame_cnt_q   <= frame_cnt_d;
            err_hperiod_q <= err_hperiod_d;
            err_hactive_q <= err_hactive_d;
            err_vtotal_q  <= err_vtotal_d;
            err_vactive_q <= err_vactive_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            locked_q      <= (state_d == StLocked);
        end
    end

    assign locked      = locked_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_hperiod = err_hperiod_q;
    assign err_hactive = err_hactive_q;
    assign err_vtotal  = err_vtotal_q;
    assign err_vactive = err_vactive_q;

endmodule
